// File: rtl/pu_obuf_ld_responder.sv
// PU OBUF load responder: accepts read beats, issues OBUF reads, and
// stores returning data in a FWFT stream FIFO guarded by a credit count.
//
// Ports:
//   clk, reset                      : clock, sync active-high reset
//   mem_req, mem_addr               : load request from address generator
//   mem_ready                       : OBUF port free (no store this cycle)
//   obuf_ld_stream_write_ready      : credit left for one more beat
//   buf_st_busy                     : store side owns the OBUF port
//   buf_rd_req, buf_rd_addr         : OBUF read port request
//   buf_rd_data                     : OBUF data, RD_LATENCY after request
//   stream_rd_req                   : consumer pop
//   stream_rd_data, stream_empty    : FIFO head and empty flag
//   idle                            : nothing stored or in flight
//   proto_err                       : sticky, request seen while not ready
module pu_obuf_ld_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 256,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_ready,
  output logic                  obuf_ld_stream_write_ready,
  input  logic                  buf_st_busy,
  output logic                  buf_rd_req,
  output logic [ADDR_WIDTH-1:0] buf_rd_addr,
  input  logic [DATA_WIDTH-1:0] buf_rd_data,
  input  logic                  stream_rd_req,
  output logic [DATA_WIDTH-1:0] stream_rd_data,
  output logic                  stream_empty,
  output logic                  idle,
  output logic                  proto_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic                  acc;
  logic                  pop;
  logic                  push;
  logic [RD_LATENCY-1:0] vld_q;
  logic [CNT_W-1:0]      credit_q;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  assign mem_ready = ~buf_st_busy;
  assign obuf_ld_stream_write_ready =
    credit_q < CNT_W'(FIFO_DEPTH);

  assign acc = mem_req & mem_ready
             & obuf_ld_stream_write_ready;

  assign buf_rd_req  = acc;
  assign buf_rd_addr = mem_addr;

  assign push = vld_q[RD_LATENCY-1];

  assign stream_empty   = (count_q == '0);
  assign pop            = stream_rd_req & ~stream_empty;
  assign stream_rd_data = mem_q[rd_ptr_q];

  // credit covers stored plus in-flight beats
  assign idle = (credit_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q     <= '0;
      credit_q  <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      proto_err <= 1'b0;
    end else begin
      vld_q[0] <= acc;
      for (int i = 1; i < RD_LATENCY; i++)
        vld_q[i] <= vld_q[i-1];

      if (acc && !pop)
        credit_q <= credit_q + CNT_W'(1);
      else if (!acc && pop)
        credit_q <= credit_q - CNT_W'(1);

      if (push && !pop)
        count_q <= count_q + CNT_W'(1);
      else if (!push && pop)
        count_q <= count_q - CNT_W'(1);

      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      if (mem_req &&
          !(mem_ready && obuf_ld_stream_write_ready))
        proto_err <= 1'b1;
    end
  end

  // storage needs no reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= buf_rd_data;
  end

endmodule

// File: tb/tb_pu_obuf_ld_responder.sv
// Bench for pu_obuf_ld_responder: directed stimulus, queue-based
// reference model checked every cycle, plus literal spot checks.
module tb_pu_obuf_ld_responder;

  localparam int AW = 8;
  localparam int DW = 256;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_req = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic          buf_st_busy = 1'b0;
  logic          stream_rd_req = 1'b0;
  logic          mem_ready;
  logic          wr_ready;
  logic          buf_rd_req;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data;
  logic [DW-1:0] stream_rd_data;
  logic          stream_empty;
  logic          idle;
  logic          proto_err;

  pu_obuf_ld_responder dut (
    .clk                        (clk),
    .reset                      (reset),
    .mem_req                    (mem_req),
    .mem_addr                   (mem_addr),
    .mem_ready                  (mem_ready),
    .obuf_ld_stream_write_ready (wr_ready),
    .buf_st_busy                (buf_st_busy),
    .buf_rd_req                 (buf_rd_req),
    .buf_rd_addr                (buf_rd_addr),
    .buf_rd_data                (buf_rd_data),
    .stream_rd_req              (stream_rd_req),
    .stream_rd_data             (stream_rd_data),
    .stream_empty               (stream_empty),
    .idle                       (idle),
    .proto_err                  (proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return {32{a ^ 8'hB7}};
  endfunction

  // OBUF: fixed two-cycle read latency
  logic [DW-1:0] ob1 = '0;
  logic [DW-1:0] ob2 = '0;
  always @(posedge clk) begin
    ob1 <= buf_rd_req ? data_of(buf_rd_addr) : '0;
    ob2 <= ob1;
  end
  assign buf_rd_data = ob2;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // reference model: stored beats, in-flight beats with due cycle
  logic [DW-1:0] m_fifo[$];
  logic [DW-1:0] m_fly[$];
  int            m_due[$];
  logic          m_perr = 1'b0;
  int            cyc = 0;
  logic          chk_en = 1'b0;
  logic          streaming = 1'b0;
  int            npop = 0;

  initial forever begin
    int  cred;
    logic do_pop, do_acc;
    @(posedge clk);
    if (reset) begin
      m_fifo.delete();
      m_fly.delete();
      m_due.delete();
      m_perr = 1'b0;
      chk_en = 1'b1;
    end else begin
      cred   = m_fifo.size() + m_fly.size();
      do_pop = stream_rd_req && m_fifo.size() > 0;
      do_acc = mem_req && !buf_st_busy && cred < D;
      if (do_pop)
        void'(m_fifo.pop_front());
      while (m_due.size() > 0 && m_due[0] == cyc) begin
        void'(m_due.pop_front());
        m_fifo.push_back(m_fly.pop_front());
      end
      if (do_acc) begin
        m_fly.push_back(data_of(mem_addr));
        m_due.push_back(cyc + 2);
      end else if (mem_req) begin
        m_perr = 1'b1;
      end
    end
    cyc++;
  end

  initial forever begin
    int   cred;
    logic e_req;
    @(negedge clk);
    if (chk_en) begin
      cred  = m_fifo.size() + m_fly.size();
      e_req = mem_req && !buf_st_busy && cred < D;
      chk("mem_ready", mem_ready, !buf_st_busy);
      chk("wr_ready", wr_ready, cred < D);
      chk("buf_rd_req", buf_rd_req, e_req);
      if (e_req)
        chk("buf_rd_addr", buf_rd_addr, mem_addr);
      chk("stream_empty", stream_empty, m_fifo.size() == 0);
      if (m_fifo.size() > 0)
        chk("head", stream_rd_data, m_fifo[0]);
      chk("idle", idle, cred == 0);
      chk("proto_err", proto_err, m_perr);
      chk("count_bound", dut.count_q <= D, 1'b1);
      if (streaming) begin
        chk("stream_count", dut.count_q <= 2, 1'b1);
        if (stream_rd_req && !stream_empty)
          npop++;
      end
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    nxt;
    nxt;
    reset = 1'b0;
    #1;
    chk("rst_empty", stream_empty, 1'b1);
    chk("rst_idle", idle, 1'b1);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_rd_req", buf_rd_req, 1'b0);
    chk("rst_perr", proto_err, 1'b0);

    // single beat
    nxt;
    mem_req  = 1'b1;
    mem_addr = 8'h12;
    #1;
    chk("sb_req", buf_rd_req, 1'b1);
    chk("sb_addr", buf_rd_addr, 8'h12);
    nxt;
    mem_req = 1'b0;
    #1;
    chk("sb_idle_t1", idle, 1'b0);
    nxt;
    #1;
    chk("sb_empty_t2", stream_empty, 1'b1);
    nxt;
    #1;
    chk("sb_empty_t3", stream_empty, 1'b0);
    chk("sb_head", stream_rd_data, {32{8'hA5}});
    stream_rd_req = 1'b1;
    nxt;
    stream_rd_req = 1'b0;
    #1;
    chk("sb_empty_t4", stream_empty, 1'b1);
    chk("sb_idle_t4", idle, 1'b1);

    // credit fill
    for (int i = 0; i < 8; i++) begin
      nxt;
      mem_req  = 1'b1;
      mem_addr = 8'h20 + 8'(i);
    end
    nxt;
    mem_addr = 8'h28;
    #1;
    chk("cf_ready0", wr_ready, 1'b0);
    chk("cf_no_req", buf_rd_req, 1'b0);
    nxt;
    mem_req = 1'b0;
    #1;
    chk("cf_perr", proto_err, 1'b1);
    repeat (3) nxt;
    stream_rd_req = 1'b1;
    #1;
    chk("cf_head", stream_rd_data, {32{8'h97}});
    nxt;
    stream_rd_req = 1'b0;
    #1;
    chk("cf_ready1", wr_ready, 1'b1);
    stream_rd_req = 1'b1;
    repeat (7) nxt;
    stream_rd_req = 1'b0;
    #1;
    chk("cf_drained", stream_empty, 1'b1);
    reset = 1'b1;
    nxt;
    reset = 1'b0;
    #1;
    chk("cf_perr_clr", proto_err, 1'b0);

    // streaming
    streaming = 1'b1;
    for (int i = 0; i < 40; i++) begin
      nxt;
      mem_req       = (i < 32);
      mem_addr      = 8'h40 + 8'(i);
      stream_rd_req = (i >= 3);
    end
    nxt;
    streaming     = 1'b0;
    mem_req       = 1'b0;
    stream_rd_req = 1'b0;
    #1;
    chk("st_beats", npop, 32);
    chk("st_idle", idle, 1'b1);

    // store conflict
    for (int i = 0; i < 3; i++) begin
      nxt;
      buf_st_busy = 1'b1;
      #1;
      chk("sc_mem_ready", mem_ready, 1'b0);
      chk("sc_no_req", buf_rd_req, 1'b0);
    end
    nxt;
    buf_st_busy = 1'b0;
    mem_req     = 1'b1;
    mem_addr    = 8'h60;
    #1;
    chk("sc_resume", buf_rd_req, 1'b1);
    nxt;
    mem_addr = 8'h61;
    nxt;
    mem_req = 1'b0;
    #1;
    chk("sc_perr", proto_err, 1'b0);
    repeat (3) nxt;
    stream_rd_req = 1'b1;
    nxt;
    nxt;
    stream_rd_req = 1'b0;
    #1;
    chk("sc_drained", stream_empty, 1'b1);

    // simultaneous accept and pop at count 4
    for (int i = 0; i < 4; i++) begin
      nxt;
      mem_req  = 1'b1;
      mem_addr = 8'h70 + 8'(i);
    end
    nxt;
    mem_req = 1'b0;
    repeat (3) nxt;
    #1;
    chk("sim_cred_pre", dut.credit_q, 4);
    mem_req       = 1'b1;
    mem_addr      = 8'h74;
    stream_rd_req = 1'b1;
    #1;
    chk("sim_head", stream_rd_data, {32{8'hC7}});
    nxt;
    mem_req       = 1'b0;
    stream_rd_req = 1'b0;
    #1;
    chk("sim_cred_post", dut.credit_q, 4);
    repeat (3) nxt;
    stream_rd_req = 1'b1;
    repeat (4) nxt;
    stream_rd_req = 1'b0;
    #1;
    chk("sim_drained", idle, 1'b1);

    // reset with a beat in flight
    nxt;
    mem_req  = 1'b1;
    mem_addr = 8'h7F;
    nxt;
    mem_req = 1'b0;
    reset   = 1'b1;
    nxt;
    reset = 1'b0;
    nxt;
    #1;
    chk("rm_empty", stream_empty, 1'b1);
    chk("rm_idle", idle, 1'b1);
    chk("rm_perr", proto_err, 1'b0);
    nxt;
    #1;
    chk("rm_empty2", stream_empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pu_obuf_ld_responder.md
# pu_obuf_ld_responder

Responder end of the PU OBUF load request interface: accepts single-beat read requests (`mem_req`/`mem_addr`) from the PU OBUF load address generator, issues them to the OBUF read port, and collects the fixed-latency read data into an internal first-word-fall-through stream FIFO that feeds the PU SIMD lanes. It owns both ready signals the requester samples. `mem_ready` reflects OBUF port arbitration against stores. `obuf_ld_stream_write_ready` is a credit check covering FIFO occupancy plus reads in flight, so the FIFO can never overflow.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: request/OBUF address width (includes the low FIFO-id bits).
- `DATA_WIDTH`, 256: OBUF read data width.
- `RD_LATENCY`, 2: cycles from `buf_rd_req` to valid `buf_rd_data`, range 1–4.
- `FIFO_DEPTH`, 8: stream FIFO entries, power of two, at least 2.
- `CNT_W`, `$clog2(FIFO_DEPTH+1)`: occupancy/credit counter width.

Ports:
- `clk`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `mem_req`, in, 1: load request; one beat per cycle while high.
- `mem_addr`, in, ADDR_WIDTH: request address.
- `mem_ready`, out, 1: OBUF read port available this cycle.
- `obuf_ld_stream_write_ready`, out, 1: credit available for one more beat.
- `buf_st_busy`, in, 1: store side owns the OBUF port this cycle.
- `buf_rd_req`, out, 1: OBUF read enable.
- `buf_rd_addr`, out, ADDR_WIDTH: OBUF read address.
- `buf_rd_data`, in, DATA_WIDTH: OBUF read data, valid RD_LATENCY cycles after `buf_rd_req`.
- `stream_rd_req`, in, 1: consumer pop.
- `stream_rd_data`, out, DATA_WIDTH: FIFO head (FWFT).
- `stream_empty`, out, 1: FIFO empty.
- `idle`, out, 1: no beats stored or in flight.
- `proto_err`, out, 1: sticky; a request arrived while not ready.

## Operation
- Accept: `acc = mem_req & mem_ready & obuf_ld_stream_write_ready`.
  - `buf_rd_req = acc` and `buf_rd_addr = mem_addr`, both combinational, same cycle.
- `mem_ready = ~buf_st_busy` (combinational).
- `obuf_ld_stream_write_ready = (credit_q < FIFO_DEPTH)`. `credit_q` is a register holding FIFO count plus in-flight beats.
- In-flight tracking: RD_LATENCY-deep valid shift register; stage 0 is loaded with `acc`. `push` is the last stage.
- On `push`, `buf_rd_data` is written into the FIFO at the write pointer the same cycle. Addresses are not stored; responses return in order.
- Pop: `pop = stream_rd_req & ~stream_empty`. A pop while empty is ignored and does not set `proto_err`.
- Credit update: `credit_d = credit_q + acc - pop`, giving +1, −1 or 0 (0 on simultaneous accept and pop).
- `proto_err` is set when `mem_req & ~(mem_ready & obuf_ld_stream_write_ready)`. The beat is dropped: no read, no credit change. The flag clears only on reset.
- FIFO: binary read/write pointers with wrap at FIFO_DEPTH and a count register. Full is unreachable by construction; the bench asserts count ≤ FIFO_DEPTH.
- `stream_rd_data` is driven from the registered storage entry at the read pointer and is don't-care when empty.
- `idle = (credit_q == 0)`.

## Timing
- Reset values: valid pipe 0, pointers 0, count 0, `credit_q` 0, `proto_err` 0.
  - Outputs after reset: `stream_empty=1`, `idle=1`, `obuf_ld_stream_write_ready=1`, `buf_rd_req=0`.
  - `mem_ready` follows `buf_st_busy` combinationally.
- Accept at cycle t: `buf_rd_req` high at t; data captured at t+RD_LATENCY.
  - `stream_empty` falls at t+RD_LATENCY+1, and head data is valid that cycle.
- Pop at cycle p: the next entry or `stream_empty=1` is visible at p+1.
- Credit: an accept at t makes `obuf_ld_stream_write_ready` reflect it from t+1; a pop at p frees a credit from p+1.
- Sustained throughput is 1 beat/cycle when the consumer pops every cycle.
- Reset mid-operation: in-flight beats are discarded; `buf_rd_data` returning after reset is ignored.

## Test plan
- Single beat: reset, then `mem_req`/`mem_addr=0x12` for 1 cycle at t, `buf_rd_data=0xA5..` at t+2 -> `buf_rd_addr=0x12` at t; `stream_empty=0` at t+3 with head `0xA5..`; pop -> `stream_empty=1`, `idle=1` next cycle.
- Credit fill: 8 back-to-back requests, no pops -> `obuf_ld_stream_write_ready=0` from cycle after the 8th accept; a 9th request sets `proto_err=1` and issues no `buf_rd_req`; one pop -> ready=1 the next cycle.
- Streaming: 32 requests and pops every cycle after the first data -> 32 beats out in order, ready never drops, count ≤ 2.
- Store conflict: `buf_st_busy=1` for 3 cycles while the requester holds `mem_req` low -> no `buf_rd_req`, `mem_ready=0` those cycles, no `proto_err`; requests then resume normally.
- Simultaneous accept and pop with count=4 -> `credit_q` unchanged and data order preserved.
- Reset mid-flight: accept at t, assert `reset` at t+1 -> `buf_rd_data` at t+2 is not stored; `stream_empty=1`, `idle=1`, `proto_err=0`.
